// File: rtl/kernel_ap_ctrl_pkg.sv
// Shared state encodings and constants for the riscv_kernel run controller.
// DONE_ADDR_DEFAULT must track the DONE word in the software linker map.
package kernel_ap_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RESET = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [29:0] DONE_ADDR_DEFAULT = 30'h100;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/kernel_ap_ctrl_if.sv
// Host handshake and dmem snoop bundle for kernel_ap_ctrl.
// master = host/SoC side, slave = controller side.
interface kernel_ap_ctrl_if #(
    parameter int AddressWidth_dmem = 30,
    parameter int DataWidth         = 32,
    parameter int CNT_WIDTH         = 32
);

    logic                         ap_start;
    logic                         ap_idle;
    logic                         ap_ready;
    logic                         ap_done;
    logic [DataWidth-1:0]         ap_return;
    logic                         timeout_flag;
    logic [CNT_WIDTH-1:0]         cycle_count;
    logic [AddressWidth_dmem-1:0] dmem_address0;
    logic                         dmem_we0;
    logic [DataWidth-1:0]         dmem_d0;

    modport master (
        output ap_start,
        output dmem_address0,
        output dmem_we0,
        output dmem_d0,
        input  ap_idle,
        input  ap_ready,
        input  ap_done,
        input  ap_return,
        input  timeout_flag,
        input  cycle_count
    );

    modport slave (
        input  ap_start,
        input  dmem_address0,
        input  dmem_we0,
        input  dmem_d0,
        output ap_idle,
        output ap_ready,
        output ap_done,
        output ap_return,
        output timeout_flag,
        output cycle_count
    );

endinterface

// File: rtl/kernel_ap_ctrl_down_counter.sv
// Loadable down-counter shared by the RESET hold and the DRAIN wait.
// Stops at zero; load has priority over decrement.
module kernel_ap_ctrl_down_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/kernel_ap_ctrl.sv
// ap_ctrl_hs run controller: holds riscv_kernel in reset while idle, runs it,
// snoops dmem for the DONE store, drains, and reports result and cycle count.
module kernel_ap_ctrl
    import kernel_ap_ctrl_pkg::*;
#(
    parameter int                           AddressWidth_dmem = 30,
    parameter int                           DataWidth         = 32,
    parameter logic [AddressWidth_dmem-1:0] DONE_ADDR         =
        AddressWidth_dmem'(DONE_ADDR_DEFAULT),
    parameter int                           RST_CYCLES        = 4,
    parameter int                           DRAIN_CYCLES      = 3,
    parameter logic [31:0]                  TIMEOUT           = 32'd1000000,
    parameter int                           CNT_WIDTH         = 32
) (
    input  logic             clk,
    input  logic             rst,
    kernel_ap_ctrl_if.slave  bus,
    output logic             core_rst
);

    localparam int CTR_W = $clog2(imax(RST_CYCLES, DRAIN_CYCLES)) + 1;
    localparam logic [CTR_W-1:0] RST_LOAD   = CTR_W'(RST_CYCLES - 1);
    localparam logic [CTR_W-1:0] DRAIN_LOAD = CTR_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT - 32'd1);

    logic [2:0]       st;
    logic [2:0]       nxt;
    logic             hit;
    logic             tmo;
    logic             ctr_load;
    logic             ctr_en;
    logic             ctr_zero;
    logic [CTR_W-1:0] ctr_val;

    assign hit = (st == ST_RUN) && bus.dmem_we0
              && (bus.dmem_address0 == DONE_ADDR);

    // A store landing on the last allowed cycle still counts as a clean finish.
    assign tmo = (st == ST_RUN) && (TIMEOUT != 32'd0)
              && (bus.cycle_count == TMO_LAST) && !hit;

    kernel_ap_ctrl_down_counter #(
        .W (CTR_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .load_val (ctr_val),
        .en       (ctr_en),
        .zero     (ctr_zero)
    );

    always_comb begin
        nxt      = st;
        ctr_load = 1'b0;
        ctr_val  = '0;
        ctr_en   = 1'b0;
        unique case (st)
            ST_IDLE: begin
                if (bus.ap_start) begin
                    nxt      = ST_RESET;
                    ctr_load = 1'b1;
                    ctr_val  = RST_LOAD;
                end
            end
            ST_RESET: begin
                if (ctr_zero) nxt = ST_RUN;
                else          ctr_en = 1'b1;
            end
            ST_RUN: begin
                if (hit || tmo) begin
                    nxt      = ST_DRAIN;
                    ctr_load = 1'b1;
                    ctr_val  = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (ctr_zero) nxt = ST_DONE;
                else          ctr_en = 1'b1;
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            st               <= ST_IDLE;
            core_rst         <= 1'b1;
            bus.ap_idle      <= 1'b1;
            bus.ap_ready     <= 1'b0;
            bus.ap_done      <= 1'b0;
            bus.ap_return    <= '0;
            bus.timeout_flag <= 1'b0;
            bus.cycle_count  <= '0;
        end else begin
            st           <= nxt;
            core_rst     <= (nxt == ST_IDLE) || (nxt == ST_RESET)
                         || (nxt == ST_DONE);
            bus.ap_idle  <= (nxt == ST_IDLE);
            bus.ap_ready <= (st == ST_RESET) && (nxt == ST_RUN);
            bus.ap_done  <= (nxt == ST_DONE);
            if ((st == ST_IDLE) && bus.ap_start) begin
                bus.ap_return    <= '0;
                bus.timeout_flag <= 1'b0;
                bus.cycle_count  <= '0;
            end
            if (st == ST_RUN) begin
                if (~&bus.cycle_count) begin
                    bus.cycle_count <= bus.cycle_count + 1'b1;
                end
                if (hit) begin
                    bus.ap_return <= bus.dmem_d0;
                end else if (tmo) begin
                    bus.ap_return    <= '1;
                    bus.timeout_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_ap_ctrl.sv
// Scenario bench for kernel_ap_ctrl: expected run results are queued at
// stimulus time and checked when ap_done appears.
module tb_kernel_ap_ctrl;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int CW = 32;
    localparam logic [AW-1:0] DADDR = 30'h100;

    typedef struct {
        logic [DW-1:0] ret;
        logic          tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst;
    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    exp_t sb[$];

    kernel_ap_ctrl_if #(
        .AddressWidth_dmem (AW),
        .DataWidth         (DW),
        .CNT_WIDTH         (CW)
    ) bus ();

    kernel_ap_ctrl #(
        .AddressWidth_dmem (AW),
        .DataWidth         (DW),
        .DONE_ADDR         (DADDR),
        .RST_CYCLES        (4),
        .DRAIN_CYCLES      (3),
        .TIMEOUT           (32'd50),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .core_rst (core_rst)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive_idle();
        bus.ap_start      = 1'b0;
        bus.dmem_we0      = 1'b0;
        bus.dmem_address0 = '0;
        bus.dmem_d0       = '0;
    endtask

    task automatic store(input logic [AW-1:0] a, input logic we,
                         input logic [DW-1:0] d);
        bus.dmem_address0 = a;
        bus.dmem_we0      = we;
        bus.dmem_d0       = d;
        @(negedge clk);
        bus.dmem_address0 = '0;
        bus.dmem_we0      = 1'b0;
        bus.dmem_d0       = '0;
    endtask

    task automatic wait_ready(input int t_exp);
        int seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (bus.ap_ready === 1'b1) seen = 1;
            else @(negedge clk);
        end
        vecs++;
        if (seen == 0 || cyc != t_exp) begin
            errs++;
            $display("FAIL ready_latency: got cycle %0d (seen=%0d), want %0d",
                     cyc, seen, t_exp);
        end
        vecs++;
        if (core_rst !== 1'b0 || bus.ap_idle !== 1'b0) begin
            errs++;
            $display("FAIL run_outputs: core_rst=%b ap_idle=%b, want 0 0",
                     core_rst, bus.ap_idle);
        end
    endtask

    task automatic start_run(input bit hold);
        int t0;
        @(negedge clk);
        bus.ap_start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        if (!hold) bus.ap_start = 1'b0;
        wait_ready(t0 + 5);
    endtask

    task automatic wait_done(input int d_exp);
        exp_t e;
        int   seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (bus.ap_done === 1'b1) seen = 1;
            else @(negedge clk);
        end
        vecs++;
        if (seen == 0 || cyc != d_exp) begin
            errs++;
            $display("FAIL done_latency: got cycle %0d (seen=%0d), want %0d",
                     cyc, seen, d_exp);
        end
        vecs++;
        if (sb.size() == 0) begin
            errs++;
            $display("FAIL scoreboard: got empty queue, want an entry");
            return;
        end
        e = sb.pop_front();
        vecs++;
        if (bus.ap_return !== e.ret) begin
            errs++;
            $display("FAIL ap_return: got %h want %h", bus.ap_return, e.ret);
        end
        vecs++;
        if (bus.timeout_flag !== e.tmo) begin
            errs++;
            $display("FAIL timeout_flag: got %b want %b",
                     bus.timeout_flag, e.tmo);
        end
        vecs++;
        if (bus.cycle_count !== e.cnt) begin
            errs++;
            $display("FAIL cycle_count: got %0d want %0d",
                     bus.cycle_count, e.cnt);
        end
        vecs++;
        if (core_rst !== 1'b1) begin
            errs++;
            $display("FAIL done_core_rst: got %b want 1", core_rst);
        end
        @(negedge clk);
        vecs++;
        if (bus.ap_done !== 1'b0 || bus.ap_idle !== 1'b1) begin
            errs++;
            $display("FAIL done_pulse: got done=%b idle=%b want 0 1",
                     bus.ap_done, bus.ap_idle);
        end
        vecs++;
        if (bus.ap_return !== e.ret || bus.cycle_count !== e.cnt
            || bus.timeout_flag !== e.tmo) begin
            errs++;
            $display("FAIL result_hold: got %h/%0d/%b want %h/%0d/%b",
                     bus.ap_return, bus.cycle_count, bus.timeout_flag,
                     e.ret, e.cnt, e.tmo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        vecs++;
        if (core_rst !== 1'b1 || bus.ap_idle !== 1'b1) begin
            errs++;
            $display("FAIL reset_ctrl: got core_rst=%b idle=%b want 1 1",
                     core_rst, bus.ap_idle);
        end
        vecs++;
        if (bus.ap_done !== 1'b0 || bus.ap_ready !== 1'b0
            || bus.timeout_flag !== 1'b0) begin
            errs++;
            $display("FAIL reset_pulses: got done=%b ready=%b tmo=%b want 0",
                     bus.ap_done, bus.ap_ready, bus.timeout_flag);
        end
        vecs++;
        if (bus.ap_return !== '0 || bus.cycle_count !== '0) begin
            errs++;
            $display("FAIL reset_data: got ret=%h cnt=%0d want 0 0",
                     bus.ap_return, bus.cycle_count);
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (bus.ap_idle !== 1'b1 || core_rst !== 1'b1) begin
            errs++;
            $display("FAIL idle_after_reset: got idle=%b core_rst=%b want 1 1",
                     bus.ap_idle, core_rst);
        end
    endtask

    task automatic test_normal();
        int h;
        start_run(1'b0);
        @(negedge clk);
        vecs++;
        if (bus.ap_ready !== 1'b0) begin
            errs++;
            $display("FAIL ready_pulse: got %b want 0", bus.ap_ready);
        end
        repeat (18) @(negedge clk);
        sb.push_back('{32'h0000_002A, 1'b0, 32'd20});
        h = cyc;
        store(DADDR, 1'b1, 32'h0000_002A);
        vecs++;
        if (bus.cycle_count !== 32'd20 || core_rst !== 1'b0) begin
            errs++;
            $display("FAIL drain_state: got cnt=%0d core_rst=%b want 20 0",
                     bus.cycle_count, core_rst);
        end
        store(DADDR, 1'b1, 32'h0BAD_0BAD);
        wait_done(h + 4);
    endtask

    task automatic test_nomatch();
        int h;
        start_run(1'b0);
        repeat (4) @(negedge clk);
        store(DADDR + 30'd1, 1'b1, 32'h1111_1111);
        vecs++;
        if (bus.cycle_count !== 32'd5 || core_rst !== 1'b0) begin
            errs++;
            $display("FAIL nomatch_addr: got cnt=%0d core_rst=%b want 5 0",
                     bus.cycle_count, core_rst);
        end
        store(DADDR, 1'b0, 32'h2222_2222);
        vecs++;
        if (bus.cycle_count !== 32'd6 || core_rst !== 1'b0) begin
            errs++;
            $display("FAIL nomatch_we: got cnt=%0d core_rst=%b want 6 0",
                     bus.cycle_count, core_rst);
        end
        repeat (8) @(negedge clk);
        sb.push_back('{32'h1234_5678, 1'b0, 32'd15});
        h = cyc;
        store(DADDR, 1'b1, 32'h1234_5678);
        wait_done(h + 4);
    endtask

    task automatic test_timeout();
        int r;
        start_run(1'b0);
        r = cyc;
        sb.push_back('{32'hFFFF_FFFF, 1'b1, 32'd50});
        wait_done(r + 53);
    endtask

    task automatic test_hit_and_timeout();
        int h;
        start_run(1'b0);
        repeat (49) @(negedge clk);
        sb.push_back('{32'hDEAD_BEEF, 1'b0, 32'd50});
        h = cyc;
        store(DADDR, 1'b1, 32'hDEAD_BEEF);
        wait_done(h + 4);
    endtask

    task automatic test_midrun_rst();
        int dones = 0;
        start_run(1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vecs++;
        if (bus.ap_idle !== 1'b1 || core_rst !== 1'b1
            || bus.ap_done !== 1'b0) begin
            errs++;
            $display("FAIL abort_state: got idle=%b core_rst=%b done=%b",
                     bus.ap_idle, core_rst, bus.ap_done);
        end
        vecs++;
        if (bus.cycle_count !== '0) begin
            errs++;
            $display("FAIL abort_count: got %0d want 0", bus.cycle_count);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.ap_done === 1'b1) dones++;
        end
        vecs++;
        if (dones != 0 || bus.ap_idle !== 1'b1) begin
            errs++;
            $display("FAIL abort_no_done: got %0d pulses idle=%b want 0 1",
                     dones, bus.ap_idle);
        end
    endtask

    task automatic test_back_to_back();
        int h;
        int t;
        start_run(1'b1);
        repeat (2) @(negedge clk);
        sb.push_back('{32'h0000_0055, 1'b0, 32'd3});
        h = cyc;
        store(DADDR, 1'b1, 32'h0000_0055);
        wait_done(h + 4);
        @(negedge clk);
        t = cyc;
        vecs++;
        if (bus.ap_idle !== 1'b0 || core_rst !== 1'b1) begin
            errs++;
            $display("FAIL restart_state: got idle=%b core_rst=%b want 0 1",
                     bus.ap_idle, core_rst);
        end
        vecs++;
        if (bus.ap_return !== '0 || bus.cycle_count !== '0) begin
            errs++;
            $display("FAIL restart_clear: got ret=%h cnt=%0d want 0 0",
                     bus.ap_return, bus.cycle_count);
        end
        bus.ap_start = 1'b0;
        wait_ready(t + 4);
        sb.push_back('{32'h0000_0066, 1'b0, 32'd1});
        h = cyc;
        store(DADDR, 1'b1, 32'h0000_0066);
        wait_done(h + 4);
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_normal();
        test_nomatch();
        test_timeout();
        test_hit_and_timeout();
        test_midrun_rst();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
